// File: rtl/datapath_gen.sv
// ============================================================================
// Module   : datapath_gen
// Purpose  : cdecv datapath: source-muxed Xbus, architectural registers, PC
//            auto-increment, optional stack pointer (DATAPATH_GEN_SP_EN) and
//            req/ack memory handshake with latched read data.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module datapath_gen #(
   parameter int DW   = 8,
   parameter int NGPR = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        xsrc,
   input  logic [8+NGPR-1:0] xdst,
   input  logic              pc_inc,
   input  logic [1:0]        sp_op,
   input  logic              mem_rd,
   input  logic              mem_wr,
   output logic [DW-1:0]     I,
   output logic [2:0]        SZCy,
   output logic              busy,
   output logic              mem_done,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic              alu_cyin,
   input  logic [DW-1:0]     alu_result,
   input  logic [2:0]        alu_szcy,
   output logic [DW-1:0]     MA,
   output logic [DW-1:0]     WD,
   input  logic [DW-1:0]     RD,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ack,
   input  logic [3:0]        dbg_addr,
   output logic [DW-1:0]     dbg_data
);

   localparam logic [DW-1:0] c_one = DW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [DW-1:0]   r_pc, r_ma, r_wd, r_ir, r_t, r_r, r_flg, r_mdr;
   logic [DW-1:0]   r_g [NGPR];
   logic [DW-1:0]   w_xbus;
   logic [DW-1:0]   w_sp;
   logic [DW-1:0]   w_flg_next;

   // Xbus source mux; GPR codes beyond NGPR and unused codes read zero.
   always_comb begin
      w_xbus = '0;
      case (xsrc)
         4'd0: w_xbus = r_pc;
         4'd1: w_xbus = r_mdr;
         4'd2: w_xbus = r_r;
         4'd3: w_xbus = r_flg;
         4'd4: w_xbus = w_sp;
         4'd5: w_xbus = '1;
         default: begin
            for (int k = 0; k < NGPR; k++)
               if (xsrc == 4'(6 + k)) w_xbus = r_g[k];
         end
      endcase
   end

   always_comb begin
      w_flg_next      = '0;
      w_flg_next[3:0] = {alu_szcy, 1'b0};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc  <= '0;
         r_ma  <= '0;
         r_wd  <= '0;
         r_ir  <= '0;
         r_t   <= '0;
         r_r   <= '0;
         r_flg <= '0;
         for (int k = 0; k < NGPR; k++) r_g[k] <= '0;
      end else begin
         if (xdst[0])     r_pc <= w_xbus;
         else if (pc_inc) r_pc <= r_pc + c_one;
         if (xdst[1]) r_ma  <= w_xbus;
         if (xdst[2]) r_wd  <= w_xbus;
         if (xdst[3]) r_ir  <= w_xbus;
         if (xdst[4]) r_t   <= w_xbus;
         if (xdst[5]) r_r   <= alu_result;
         if (xdst[6]) r_flg <= w_flg_next;
         for (int k = 0; k < NGPR; k++)
            if (xdst[8+k]) r_g[k] <= w_xbus;
      end
   end

`ifdef DATAPATH_GEN_SP_EN
   logic [DW-1:0] r_sp;

   always_ff @(posedge clock) begin
      if (reset)        r_sp <= '0;
      else if (xdst[7]) r_sp <= w_xbus;
      else begin
         case (sp_op)
            2'b01:   r_sp <= r_sp + c_one;
            2'b10:   r_sp <= r_sp - c_one;
            default: r_sp <= r_sp;
         endcase
      end
   end

   assign w_sp = r_sp;
`else
   logic unused_sp;

   assign unused_sp = ^{sp_op, xdst[7]};
   assign w_sp      = '0;
`endif

   // Handshake FSM; MDR captures RD on the ack edge of a read only.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         busy     <= 1'b0;
         mem_done <= 1'b0;
         r_mdr    <= '0;
      end else begin
         case (r_state)
            ST_REQ: begin
               if (mem_ack) begin
                  if (!mem_we) r_mdr <= RD;
                  r_state  <= ST_DONE;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  busy     <= 1'b0;
                  mem_done <= 1'b1;
               end
            end
            default: begin
               mem_done <= 1'b0;
               if (mem_rd || mem_wr) begin
                  r_state <= ST_REQ;
                  mem_req <= 1'b1;
                  mem_we  <= mem_wr;
                  busy    <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      dbg_data = '0;
      case (dbg_addr)
         4'd0: dbg_data = r_pc;
         4'd1: dbg_data = r_t;
         4'd2: dbg_data = r_r;
         4'd3: dbg_data = r_flg;
         4'd4: dbg_data = w_sp;
         4'd5: dbg_data = w_xbus;
         default: begin
            for (int k = 0; k < NGPR; k++)
               if (dbg_addr == 4'(6 + k)) dbg_data = r_g[k];
         end
      endcase
   end

   assign I        = r_ir;
   assign SZCy     = r_flg[3:1];
   assign alu_a    = w_xbus;
   assign alu_b    = r_t;
   assign alu_cyin = r_flg[1];
   assign MA       = r_ma;
   assign WD       = r_wd;

endmodule

`default_nettype wire

// File: tb/tb_datapath_gen.sv
// ============================================================================
// Module   : tb_datapath_gen
// Purpose  : directed self-checking bench for datapath_gen (DW=8/NGPR=3 and
//            DW=16/NGPR=8 instances).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_datapath_gen;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  xsrc;
   logic [10:0] xdst;
   logic        pc_inc;
   logic [1:0]  sp_op;
   logic        mem_rd, mem_wr, mem_ack;
   logic [7:0]  alu_result, RD;
   logic [2:0]  alu_szcy;
   logic [3:0]  dbg_addr;
   logic [7:0]  I, alu_a, alu_b, MA, WD, dbg_data;
   logic [2:0]  SZCy;
   logic        busy, mem_done, alu_cyin, mem_req, mem_we;

   logic [3:0]  xsrc2, dbg_addr2;
   logic [15:0] xdst2;
   logic [15:0] I2, alu_a2, alu_b2, MA2, WD2, dbg_data2;
   logic [2:0]  SZCy2;
   logic        busy2, mem_done2, alu_cyin2, mem_req2, mem_we2;

   int checks = 0;
   int errors = 0;

`ifdef DATAPATH_GEN_SP_EN
   localparam bit SP_ON = 1'b1;
`else
   localparam bit SP_ON = 1'b0;
`endif

   always #5 clock = ~clock;

   datapath_gen #(.DW(8), .NGPR(3)) dut8 (
      .clock(clock), .reset(reset), .xsrc(xsrc), .xdst(xdst), .pc_inc(pc_inc),
      .sp_op(sp_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .I(I), .SZCy(SZCy),
      .busy(busy), .mem_done(mem_done), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cyin(alu_cyin), .alu_result(alu_result), .alu_szcy(alu_szcy),
      .MA(MA), .WD(WD), .RD(RD), .mem_req(mem_req), .mem_we(mem_we),
      .mem_ack(mem_ack), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   datapath_gen #(.DW(16), .NGPR(8)) dut16 (
      .clock(clock), .reset(reset), .xsrc(xsrc2), .xdst(xdst2), .pc_inc(1'b0),
      .sp_op(2'b00), .mem_rd(1'b0), .mem_wr(1'b0), .I(I2), .SZCy(SZCy2),
      .busy(busy2), .mem_done(mem_done2), .alu_a(alu_a2), .alu_b(alu_b2),
      .alu_cyin(alu_cyin2), .alu_result(16'h0000), .alu_szcy(3'b000),
      .MA(MA2), .WD(WD2), .RD(16'h0000), .mem_req(mem_req2), .mem_we(mem_we2),
      .mem_ack(1'b0), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      dbg_addr = a;
      #0.2;
      check(tag, 32'(dbg_data), exp);
   endtask

   initial begin
      reset = 1'b1; xsrc = '0; xdst = '0; pc_inc = 1'b0; sp_op = '0;
      mem_rd = 1'b0; mem_wr = 1'b0; mem_ack = 1'b0; alu_result = '0; RD = '0;
      alu_szcy = '0; dbg_addr = '0; xsrc2 = '0; xdst2 = '0; dbg_addr2 = '0;
      step(); step();
      reset = 1'b0;

      // Reset state
      for (int a = 0; a < 9; a++) dbg_chk($sformatf("rst_dbg%0d", a), 4'(a), 32'h0);
      check("rst_req", 32'(mem_req), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(mem_done), 32'h0);
      check("rst_I", 32'(I), 32'h0);

      // PC: write beats increment, then increment wraps
      xsrc = 4'd5; xdst = 11'h001; pc_inc = 1'b1; step();
      xdst = '0;
      dbg_chk("pc_write_prio", 4'd0, 32'hFF);
      step();
      pc_inc = 1'b0;
      dbg_chk("pc_wrap", 4'd0, 32'h00);

      // G2 = 0x33 via R, MA = 0x20 via R
      alu_result = 8'h33; xdst = 11'h020; step();
      xsrc = 4'd2; xdst = 11'h400; step();
      dbg_chk("g2_write", 4'd8, 32'h33);
      alu_result = 8'h20; xdst = 11'h020; step();
      xdst = 11'h002; step();
      xdst = '0;
      check("ma_write", 32'(MA), 32'h20);

      // Read handshake, ack sampled on the third edge after the request edge
      mem_rd = 1'b1; step();
      mem_rd = 1'b0;
      check("rd_req1", 32'(mem_req), 32'h1);
      check("rd_busy", 32'(busy), 32'h1);
      check("rd_we", 32'(mem_we), 32'h0);
      mem_rd = 1'b1; step();
      mem_rd = 1'b0;
      check("rd_req2", 32'(mem_req), 32'h1);
      step();
      check("rd_req3", 32'(mem_req), 32'h1);
      mem_ack = 1'b1; RD = 8'h5A; step();
      mem_ack = 1'b0; RD = 8'h00;
      check("rd_req_drop", 32'(mem_req), 32'h0);
      check("rd_done", 32'(mem_done), 32'h1);
      check("rd_busy_done", 32'(busy), 32'h0);
      step();
      check("rd_done_pulse", 32'(mem_done), 32'h0);
      xsrc = 4'd1; #0.2;
      check("rd_mdr_xbus", 32'(alu_a), 32'h5A);

      // Simultaneous rd+wr: write wins, MDR untouched
      mem_rd = 1'b1; mem_wr = 1'b1; step();
      mem_rd = 1'b0; mem_wr = 1'b0;
      check("wr_we", 32'(mem_we), 32'h1);
      check("wr_req", 32'(mem_req), 32'h1);
      mem_ack = 1'b1; RD = 8'h77; step();
      mem_ack = 1'b0;
      check("wr_done", 32'(mem_done), 32'h1);
      check("wr_mdr_hold", 32'(alu_a), 32'h5A);

      // Request accepted in DONE goes straight to REQ
      mem_rd = 1'b1; step();
      mem_rd = 1'b0;
      check("done_rereq", 32'(mem_req), 32'h1);
      check("done_rereq_pulse", 32'(mem_done), 32'h0);
      mem_ack = 1'b1; RD = 8'hC3; step();
      mem_ack = 1'b0;
      check("done_rd_mdr", 32'(alu_a), 32'hC3);
      step();

      // T, I, WD
      xsrc = 4'd5; xdst = 11'h014; step();
      xsrc = 4'd1; xdst = 11'h008; step();
      xdst = '0;
      check("t_alu_b", 32'(alu_b), 32'hFF);
      check("wd_write", 32'(WD), 32'hFF);
      check("i_write", 32'(I), 32'hC3);

      // R and FLG from the ALU
      alu_result = 8'h00; alu_szcy = 3'b011; xdst = 11'h060; step();
      xdst = '0;
      dbg_chk("r_alu", 4'd2, 32'h00);
      dbg_chk("flg_alu", 4'd3, 32'h06);
      check("szcy", 32'(SZCy), 32'h3);
      check("cyin", 32'(alu_cyin), 32'h1);

      // Stack pointer
      sp_op = 2'b10; step();
      sp_op = 2'b00;
      dbg_chk("sp_dec_wrap", 4'd4, SP_ON ? 32'hFF : 32'h0);
      xsrc = 4'd8; xdst = 11'h080; sp_op = 2'b01; step();
      xdst = '0; sp_op = 2'b00;
      dbg_chk("sp_write_prio", 4'd4, SP_ON ? 32'h33 : 32'h0);
      xsrc = 4'd4; #0.2;
      check("sp_xbus", 32'(alu_a), SP_ON ? 32'h33 : 32'h0);
      sp_op = 2'b01; step();
      sp_op = 2'b00;
      dbg_chk("sp_inc", 4'd4, SP_ON ? 32'h34 : 32'h0);

      // DW=16, NGPR=8 instance
      xsrc2 = 4'd5; xdst2 = 16'h8000; step();
      xdst2 = '0; dbg_addr2 = 4'd13; #0.2;
      check("p16_g7", 32'(dbg_data2), 32'hFFFF);
      dbg_addr2 = 4'd6; #0.2;
      check("p16_g0", 32'(dbg_data2), 32'h0);
      xsrc2 = 4'd14; #0.2;
      check("p16_gpr8", 32'(alu_a2), 32'h0);
      xsrc2 = 4'd13; #0.2;
      check("p16_xbus_g7", 32'(alu_a2), 32'hFFFF);

      // Reset in the middle of REQ
      mem_rd = 1'b1; step();
      mem_rd = 1'b0;
      check("mid_req", 32'(mem_req), 32'h1);
      reset = 1'b1; mem_ack = 1'b0; step();
      check("mid_rst_req", 32'(mem_req), 32'h0);
      step();
      reset = 1'b0;
      check("mid_rst_busy", 32'(busy), 32'h0);
      for (int a = 0; a < 9; a++) dbg_chk($sformatf("mid_rst_dbg%0d", a), 4'(a), 32'h0);
      xsrc = 4'd1; #0.2;
      check("mid_rst_mdr", 32'(alu_a), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
